// File: rtl/serial_frame_rx_if.sv
// Bus bundle for serial_frame_rx: serial input side, word handshake and status pulses.
// master = stimulus/consumer side, slave = the receiver.
interface serial_frame_rx_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sen;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             dready;
  logic             busy;
  logic             ovf;
  logic             perr;

  modport master (
    output sin, sen, dready,
    input  dout, dvalid, busy, ovf, perr
  );

  modport slave (
    input  sin, sen, dready,
    output dout, dvalid, busy, ovf, perr
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB-first, optional even parity.
// Optional parity check is enabled by defining PARITY_CHECK_EN.
module serial_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic              CLK,
  input  logic              RES,
  serial_frame_rx_if.slave  bus,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] dout_q;
  logic             dvalid_q;
  logic             ovf_q;
  logic             perr_q;
  logic             hold_free;

  // Handshake: dout/dvalid hold a word until an edge with dready=1; dready is
  // ignored while dvalid=0. A word being read on this edge frees the slot.
  assign hold_free = !dvalid_q || bus.dready;

  always_comb begin
    shreg_next = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) shreg_next[i] = bus.sin;
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
      if (dvalid_q && bus.dready) dvalid_q <= 1'b0;
      if (bus.sen) begin
        case (state)
          IDLE: begin
            if (bus.sin) begin
              shreg <= '0;
              cnt   <= '0;
              state <= DATA;
            end
          end
          DATA: begin
            shreg <= shreg_next;
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
              state <= PAR;
`else
              state <= IDLE;
              if (hold_free) begin
                dout_q   <= shreg_next;
                dvalid_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef PARITY_CHECK_EN
          PAR: begin
            state <= IDLE;
            // Even parity: data bits XOR parity bit must be zero.
            if (^{shreg, bus.sin}) begin
              perr_q <= 1'b1;
            end else if (hold_free) begin
              dout_q   <= shreg;
              dvalid_q <= 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.busy   = (state != IDLE);
  assign bus.ovf    = ovf_q;
  assign bus.perr   = perr_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: table-driven frames plus hand-written
// reset, overrun, parity and back-to-back sequences, with a word scoreboard.
module tb_serial_frame_rx;
  localparam int W = 4;

  logic       CLK = 1'b0;
  logic       RES = 1'b0;
  logic [1:0] state_dbg;

  serial_frame_rx_if #(.WIDTH(W)) bus();

  serial_frame_rx #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int errors   = 0;
  int ovf_cnt  = 0;
  int perr_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  typedef struct {
    logic [W-1:0] word;
    int           stalls;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a word is consumed on an edge where dvalid and dready are both high.
  always @(negedge CLK) begin
    if (RES && bus.dvalid && bus.dready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.dout);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard_dout", 32'(bus.dout), 32'(mon_exp));
      end
    end
    if (bus.ovf)  ovf_cnt++;
    if (bus.perr) perr_cnt++;
    if (bus.ovf && bus.perr) begin
      checks++;
      errors++;
      $display("FAIL ovf_perr_together: got 1 expected 0");
    end
  end

  task automatic step(input logic s_en, input logic s_in);
    bus.sen = s_en;
    bus.sin = s_in;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int stalls,
                            input logic par_bad, input logic ready_last);
    step(1'b1, 1'b1);
    for (int i = 0; i < W; i++) begin
      for (int s = 0; s < stalls; s++) begin
        step(1'b0, 1'($urandom_range(0, 1)));
        check("busy_stall", 32'(bus.busy), 32'd1);
      end
`ifndef PARITY_CHECK_EN
      if (i == W - 1 && ready_last) bus.dready = 1'b1;
`endif
      step(1'b1, w[i]);
    end
`ifdef PARITY_CHECK_EN
    if (ready_last) bus.dready = 1'b1;
    step(1'b1, (^w) ^ par_bad);
`endif
    bus.sen = 1'b0;
    if (ready_last) bus.dready = 1'b0;
  endtask

  task automatic drain();
    bus.dready = 1'b1;
    step(1'b0, 1'b0);
    bus.dready = 1'b0;
    check("dvalid_cleared", 32'(bus.dvalid), 32'd0);
  endtask

  initial begin
    bus.sin    = 1'b0;
    bus.sen    = 1'b0;
    bus.dready = 1'b0;

    tbl[0] = '{4'hD, 0};
    tbl[1] = '{4'hD, 2};
    tbl[2] = '{4'h0, 0};
    tbl[3] = '{4'hF, 1};
    tbl[4] = '{4'hA, 0};
    tbl[5] = '{4'h5, 3};
    tbl[6] = '{4'($urandom_range(0, 15)), 0};
    tbl[7] = '{4'($urandom_range(0, 15)), int'($urandom_range(0, 2))};

    // Power-on reset with strobes toggling
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("reset_dout",   32'(bus.dout),   32'd0);
    check("reset_dvalid", 32'(bus.dvalid), 32'd0);
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_ovf",    32'(bus.ovf),    32'd0);
    check("reset_perr",   32'(bus.perr),   32'd0);
    RES = 1'b1;
    step(1'b0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(tbl[v].word);
      send_frame(tbl[v].word, tbl[v].stalls, 1'b0, 1'b0);
      check("vec_dvalid", 32'(bus.dvalid), 32'd1);
      check("vec_dout",   32'(bus.dout),   32'(tbl[v].word));
      check("vec_busy",   32'(bus.busy),   32'd0);
      drain();
    end

    // Reset in the middle of a frame: partial word lost, dout cleared
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("midframe_busy", 32'(bus.busy), 32'd1);
    RES = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_dout", 32'(bus.dout), 32'd0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("midrst_hold_busy",   32'(bus.busy),   32'd0);
    check("midrst_hold_dvalid", 32'(bus.dvalid), 32'd0);
    check("midrst_hold_pulses", 32'({bus.ovf, bus.perr}), 32'd0);
    RES = 1'b1;
    step(1'b0, 1'b0);
    exp_q.push_back(4'h6);
    send_frame(4'h6, 0, 1'b0, 1'b0);
    check("post_rst_dout", 32'(bus.dout), 32'h6);
    drain();

    // Overrun: holding register full, second word dropped
    exp_q.push_back(4'hD);
    send_frame(4'hD, 0, 1'b0, 1'b0);
    check("ovr_first_dvalid", 32'(bus.dvalid), 32'd1);
    send_frame(4'h3, 0, 1'b0, 1'b0);
    check("ovr_pulse",  32'(bus.ovf),    32'd1);
    check("ovr_dout",   32'(bus.dout),   32'hD);
    check("ovr_dvalid", 32'(bus.dvalid), 32'd1);
    step(1'b0, 1'b0);
    check("ovr_pulse_one_cycle", 32'(bus.ovf), 32'd0);
    drain();

    // Read on the completing edge frees the slot: no overrun
    exp_q.push_back(4'hD);
    send_frame(4'hD, 0, 1'b0, 1'b0);
    exp_q.push_back(4'h3);
    send_frame(4'h3, 0, 1'b0, 1'b1);
    check("same_edge_ovf",    32'(bus.ovf),    32'd0);
    check("same_edge_dout",   32'(bus.dout),   32'h3);
    check("same_edge_dvalid", 32'(bus.dvalid), 32'd1);
    drain();

`ifdef PARITY_CHECK_EN
    exp_q.push_back(4'hD);
    send_frame(4'hD, 0, 1'b0, 1'b0);
    check("par_ok_dvalid", 32'(bus.dvalid), 32'd1);
    check("par_ok_dout",   32'(bus.dout),   32'hD);
    drain();
    send_frame(4'hD, 0, 1'b1, 1'b0);
    check("par_bad_perr",   32'(bus.perr),   32'd1);
    check("par_bad_dvalid", 32'(bus.dvalid), 32'd0);
    step(1'b0, 1'b0);
    check("par_bad_perr_one_cycle", 32'(bus.perr), 32'd0);
`endif

    // Back-to-back frames with the consumer always ready
    bus.dready = 1'b1;
    exp_q.push_back(4'hA);
    send_frame(4'hA, 0, 1'b0, 1'b0);
    check("b2b_first_dout", 32'(bus.dout), 32'hA);
    exp_q.push_back(4'h5);
    send_frame(4'h5, 0, 1'b0, 1'b0);
    check("b2b_second_dout", 32'(bus.dout), 32'h5);
    step(1'b0, 1'b0);
    bus.dready = 1'b0;
    check("b2b_drained", 32'(bus.dvalid), 32'd0);

    step(1'b0, 1'b0);
    check("ovf_total", 32'(ovf_cnt), 32'd1);
`ifdef PARITY_CHECK_EN
    check("perr_total", 32'(perr_cnt), 32'd1);
`else
    check("perr_total", 32'(perr_cnt), 32'd0);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
